// File: rtl/btb_pkg.sv
// Shared definitions for the branch target predictor table: predictor encodings,
// flush FSM states and PC field helpers.
package btb_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_t;

   function automatic logic [1:0] sat_inc2(input logic [1:0] s);
      case (s)
         SNT:     return WNT;
         WNT:     return WT;
         default: return ST;
      endcase
   endfunction

   function automatic logic [1:0] sat_dec2(input logic [1:0] s);
      case (s)
         ST:      return WT;
         WT:      return WNT;
         default: return SNT;
      endcase
   endfunction

   // Word-aligned PCs: the two low bits never contribute to index or tag.
   function automatic logic [31:0] pc_index(input logic [63:0] pc, input int idx_w);
      return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
   endfunction

   function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
      return 32'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
   endfunction

endpackage

// File: rtl/btb_flush_seq.sv
// Flush sequencer: walks every table index once, one per cycle, after a flush request.
module btb_flush_seq
   import btb_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_req,
   output logic                       flush_busy,
   output logic                       clr_en,
   output logic [$clog2(ENTRIES)-1:0] clr_idx
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   flush_state_t     state_q;
   logic [IDX_W-1:0] idx_q;

   // A new request always restarts the walk from index 0, even mid-flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else if (flush_req) begin
         state_q <= FLUSH;
         idx_q   <= '0;
      end else if (state_q == FLUSH) begin
         if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            idx_q   <= '0;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign flush_busy = (state_q == FLUSH);
   assign clr_en     = (state_q == FLUSH);
   assign clr_idx    = idx_q;

endmodule

// File: rtl/branch_target_predictor_table.sv
// Tagged BTB with 2-bit saturating predictors and a sequenced table flush.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_predictor_table
   import btb_pkg::*;
#(
   parameter int         PC_W     = 32,
   parameter int         ENTRIES  = 64,
   parameter int         TAG_W    = 8,
   parameter logic [1:0] CTR_INIT = WT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lookup_en,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            hit,
   output logic            predict_taken,
   output logic [PC_W-1:0] predict_pc,
   output logic [1:0]      pred_state,
   input  logic            update,
   input  logic [PC_W-1:0] update_pc,
   input  logic [PC_W-1:0] update_target,
   input  logic            update_taken,
   input  logic            flush_req,
   output logic            flush_busy,
   output logic [31:0]     stat_lookups,
   output logic [31:0]     stat_hits,
   output logic [31:0]     stat_allocs
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [1:0]         ctr_mem [ENTRIES];
   logic [PC_W-1:0]    tgt_mem [ENTRIES];

   logic [IDX_W-1:0] l_idx, u_idx, clr_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             l_hit, u_hit, upd_ok, do_train, do_alloc, clr_en;

   btb_flush_seq #(.ENTRIES(ENTRIES)) u_flush_seq (
      .clk        (clk),
      .reset      (reset),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .clr_en     (clr_en),
      .clr_idx    (clr_idx)
   );

   assign l_idx = IDX_W'(pc_index(64'(lookup_pc), IDX_W));
   assign l_tag = TAG_W'(pc_tag(64'(lookup_pc), IDX_W, TAG_W));
   assign u_idx = IDX_W'(pc_index(64'(update_pc), IDX_W));
   assign u_tag = TAG_W'(pc_tag(64'(update_pc), IDX_W, TAG_W));

   assign l_hit         = lookup_en && !flush_busy && valid_q[l_idx] && (tag_mem[l_idx] == l_tag);
   assign hit           = l_hit;
   assign predict_taken = l_hit && ctr_mem[l_idx][1];
   assign predict_pc    = l_hit ? tgt_mem[l_idx] : '0;
   assign pred_state    = l_hit ? ctr_mem[l_idx] : SNT;

   // An update arriving with a flush request would be wiped anyway, so drop it.
   assign upd_ok   = update && !flush_busy && !flush_req;
   assign u_hit    = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
   assign do_train = upd_ok && u_hit;
   assign do_alloc = upd_ok && !u_hit && update_taken;

   // Payload arrays carry no reset; an entry is only meaningful once its valid bit is set.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         tag_mem[u_idx] <= u_tag;
         tgt_mem[u_idx] <= update_target;
         ctr_mem[u_idx] <= CTR_INIT;
      end else if (do_train) begin
         ctr_mem[u_idx] <= update_taken ? sat_inc2(ctr_mem[u_idx]) : sat_dec2(ctr_mem[u_idx]);
         if (update_taken) begin
            tgt_mem[u_idx] <= update_target;
         end
      end
   end

   // Clears and allocations never coincide because updates are ignored while flushing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
         end
         if (do_alloc) begin
            valid_q[u_idx] <= 1'b1;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] cnt_lookups, cnt_hits, cnt_allocs;

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_lookups <= '0;
         cnt_hits    <= '0;
         cnt_allocs  <= '0;
      end else if (flush_req) begin
         cnt_lookups <= '0;
         cnt_hits    <= '0;
         cnt_allocs  <= '0;
      end else begin
         if (lookup_en && !flush_busy && (cnt_lookups != '1)) begin
            cnt_lookups <= cnt_lookups + 32'd1;
         end
         if (l_hit && (cnt_hits != '1)) begin
            cnt_hits <= cnt_hits + 32'd1;
         end
         if (do_alloc && (cnt_allocs != '1)) begin
            cnt_allocs <= cnt_allocs + 32'd1;
         end
      end
   end

   assign stat_lookups = cnt_lookups;
   assign stat_hits    = cnt_hits;
   assign stat_allocs  = cnt_allocs;
`else
   assign stat_lookups = '0;
   assign stat_hits    = '0;
   assign stat_allocs  = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor_table.sv
// Scoreboard bench for branch_target_predictor_table: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_branch_target_predictor_table;

   localparam int PC_W    = 32;
   localparam int ENTRIES = 64;
`ifdef BTB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            lookup_en = 1'b0;
   logic [PC_W-1:0] lookup_pc = '0;
   logic            hit, predict_taken, flush_busy;
   logic [PC_W-1:0] predict_pc;
   logic [1:0]      pred_state;
   logic            update = 1'b0;
   logic [PC_W-1:0] update_pc = '0;
   logic [PC_W-1:0] update_target = '0;
   logic            update_taken = 1'b0;
   logic            flush_req = 1'b0;
   logic [31:0]     stat_lookups, stat_hits, stat_allocs;

   branch_target_predictor_table #(.PC_W(PC_W), .ENTRIES(ENTRIES), .TAG_W(8), .CTR_INIT(2'b10)) dut (
      .clk           (clk),
      .reset         (reset),
      .lookup_en     (lookup_en),
      .lookup_pc     (lookup_pc),
      .hit           (hit),
      .predict_taken (predict_taken),
      .predict_pc    (predict_pc),
      .pred_state    (pred_state),
      .update        (update),
      .update_pc     (update_pc),
      .update_target (update_target),
      .update_taken  (update_taken),
      .flush_req     (flush_req),
      .flush_busy    (flush_busy),
      .stat_lookups  (stat_lookups),
      .stat_hits     (stat_hits),
      .stat_allocs   (stat_allocs)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        busy;
      logic [31:0] sl;
      logic [31:0] sh;
      logic [31:0] sa;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    failures = 0;
   logic  chk_req = 1'b0;
   int    m_lookups = 0, m_hits = 0, m_allocs = 0;

   localparam logic [31:0] PC_A = 32'h0040_0010;
   localparam logic [31:0] PC_B = 32'h0040_0110;
   localparam logic [31:0] PC_C = 32'h0040_0020;
   localparam logic [31:0] PC_D = 32'h0040_0030;
   localparam logic [31:0] PC_E = 32'h0040_0040;
   localparam logic [31:0] PC_F = 32'h0040_0050;
   localparam logic [31:0] PC_G = 32'h0040_0060;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s.%s got=0x%0h exp=0x%0h", nm, fld, act, exp);
      end
   endtask

   task automatic checkOutput(input string nm, input exp_t e);
      cmp(nm, "hit",           32'(hit),           32'(e.hit));
      cmp(nm, "predict_taken", 32'(predict_taken), 32'(e.taken));
      cmp(nm, "predict_pc",    predict_pc,         e.pc);
      cmp(nm, "pred_state",    32'(pred_state),    32'(e.st));
      cmp(nm, "flush_busy",    32'(flush_busy),    32'(e.busy));
      cmp(nm, "stat_lookups",  stat_lookups,       e.sl);
      cmp(nm, "stat_hits",     stat_hits,          e.sh);
      cmp(nm, "stat_allocs",   stat_allocs,        e.sa);
   endtask

   // Monitor: consumes one expectation per flagged cycle, mid-cycle.
   always @(negedge clk) begin
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got=0 exp=1");
         end else begin
            checkOutput(name_q.pop_front(), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input string nm, input logic l_en, input logic [31:0] l_pc,
                                input logic u_en, input logic [31:0] u_pc, input logic [31:0] u_tgt,
                                input logic u_tk, input logic f_req, input logic e_hit,
                                input logic [31:0] e_pc, input logic [1:0] e_st, input logic e_busy,
                                input logic alloc);
      exp_t e;
      lookup_en     = l_en;
      lookup_pc     = l_pc;
      update        = u_en;
      update_pc     = u_pc;
      update_target = u_tgt;
      update_taken  = u_tk;
      flush_req     = f_req;
      chk_req       = 1'b1;
      e.hit   = e_hit;
      e.taken = e_hit && e_st[1];
      e.pc    = e_pc;
      e.st    = e_st;
      e.busy  = e_busy;
      e.sl    = STATS ? 32'(m_lookups) : 32'd0;
      e.sh    = STATS ? 32'(m_hits)    : 32'd0;
      e.sa    = STATS ? 32'(m_allocs)  : 32'd0;
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (f_req) begin
         m_lookups = 0;
         m_hits    = 0;
         m_allocs  = 0;
      end else begin
         if (l_en && !e_busy) m_lookups++;
         if (e_hit) m_hits++;
         if (alloc) m_allocs++;
      end
      tick();
   endtask

   task automatic idle();
      lookup_en = 1'b0;
      update    = 1'b0;
      flush_req = 1'b0;
      chk_req   = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] rot[4];
      rot[0] = PC_B; rot[1] = PC_C; rot[2] = PC_D; rot[3] = PC_E;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      applyStimulus("reset",       1, PC_A, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("alloc_nobyp", 1, PC_A, 1, PC_A, 32'h0040_0100, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("first_hit",   1, PC_A, 1, PC_A, 32'hDEAD_0000, 0, 0, 1, 32'h0040_0100, 2'b10, 0, 0);
      applyStimulus("nt1",         1, PC_A, 1, PC_A, 32'hDEAD_0000, 0, 0, 1, 32'h0040_0100, 2'b01, 0, 0);
      applyStimulus("nt2",         1, PC_A, 1, PC_A, 32'hDEAD_0000, 0, 0, 1, 32'h0040_0100, 2'b00, 0, 0);
      applyStimulus("nt3_sat",     1, PC_A, 0, 0, 0, 0, 0, 1, 32'h0040_0100, 2'b00, 0, 0);
      applyStimulus("tk_retarget", 1, PC_A, 1, PC_A, 32'h0040_0200, 1, 0, 1, 32'h0040_0100, 2'b00, 0, 0);
      applyStimulus("tk1",         1, PC_A, 1, PC_A, 32'h0040_0200, 1, 0, 1, 32'h0040_0200, 2'b01, 0, 0);
      applyStimulus("tk2",         1, PC_A, 1, PC_A, 32'h0040_0200, 1, 0, 1, 32'h0040_0200, 2'b10, 0, 0);
      applyStimulus("tk3",         1, PC_A, 0, 0, 0, 0, 0, 1, 32'h0040_0200, 2'b11, 0, 0);
      applyStimulus("alias_alloc", 1, PC_A, 1, PC_B, 32'h0040_0300, 1, 0, 1, 32'h0040_0200, 2'b11, 0, 1);
      applyStimulus("alias_oldpc", 1, PC_A, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("alias_newpc", 1, PC_B, 0, 0, 0, 0, 0, 1, 32'h0040_0300, 2'b10, 0, 0);
      applyStimulus("nt_miss",     1, PC_C, 1, PC_C, 32'h0040_0400, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("nt_nowrite",  1, PC_C, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("lookup_off",  0, PC_B, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("alloc_c",     0, 0, 1, PC_C, 32'h0040_0400, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("alloc_d",     0, 0, 1, PC_D, 32'h0040_0500, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("alloc_e",     0, 0, 1, PC_E, 32'h0040_0600, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("hit_c",       1, PC_C, 0, 0, 0, 0, 0, 1, 32'h0040_0400, 2'b10, 0, 0);
      applyStimulus("hit_d",       1, PC_D, 0, 0, 0, 0, 0, 1, 32'h0040_0500, 2'b10, 0, 0);
      applyStimulus("hit_e",       1, PC_E, 0, 0, 0, 0, 0, 1, 32'h0040_0600, 2'b10, 0, 0);

      applyStimulus("flush_req",   1, PC_B, 1, PC_F, 32'h0040_0700, 1, 1, 1, 32'h0040_0300, 2'b10, 0, 0);
      for (int i = 0; i < ENTRIES; i++) begin
         applyStimulus("flush_busy", 1, rot[i % 4], (i % 2 == 0), PC_G, 32'h0040_0800, 1, 0,
                       0, 0, 2'b00, 1, 0);
      end
      applyStimulus("post_b",      1, PC_B, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("post_c",      1, PC_C, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("post_d",      1, PC_D, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("post_e",      1, PC_E, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("post_f_drop", 1, PC_F, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("post_g_drop", 1, PC_G, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("realloc_a",   0, 0, 1, PC_A, 32'h0040_0A00, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("realloc_c",   0, 0, 1, PC_C, 32'h0040_0B00, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("st_hit_a1",   1, PC_A, 0, 0, 0, 0, 0, 1, 32'h0040_0A00, 2'b10, 0, 0);
      applyStimulus("st_hit_c1",   1, PC_C, 0, 0, 0, 0, 0, 1, 32'h0040_0B00, 2'b10, 0, 0);
      applyStimulus("st_hit_a2",   1, PC_A, 0, 0, 0, 0, 0, 1, 32'h0040_0A00, 2'b10, 0, 0);
      applyStimulus("st_hit_c2",   1, PC_C, 0, 0, 0, 0, 0, 1, 32'h0040_0B00, 2'b10, 0, 0);
      idle();
      #3;
      cmp("stats_total", "lookups", stat_lookups, STATS ? 32'd10 : 32'd0);
      cmp("stats_total", "hits",    stat_hits,    STATS ? 32'd4  : 32'd0);
      cmp("stats_total", "allocs",  stat_allocs,  STATS ? 32'd2  : 32'd0);
      tick();

      applyStimulus("flush2_req",  1, PC_A, 0, 0, 0, 0, 1, 1, 32'h0040_0A00, 2'b10, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("flush2_busy", 1, PC_A, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
      end
      chk_req = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      m_lookups = 0;
      m_hits    = 0;
      m_allocs  = 0;
      applyStimulus("midrst_a",    1, PC_A, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("midrst_c",    1, PC_C, 1, PC_A, 32'h0040_0900, 1, 0, 0, 0, 2'b00, 0, 1);
      applyStimulus("midrst_real", 1, PC_A, 0, 0, 0, 0, 0, 1, 32'h0040_0900, 2'b10, 0, 0);
      idle();
      idle();

      cmp("scoreboard", "leftover", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

endmodule
